// File: rtl/alu_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Brief    : Issue/writeback controller for the external 8-bit ALU, with an
//            8x8 register file and NZCV flags. Optional ALU_SEQUENCER_RETIRE_CNT_EN
//            adds a 16-bit retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
    parameter int NREGS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_op,
    output logic [2:0]  alu_shamt,
    input  logic [7:0]  alu_out,
    input  logic        ld_en,
    input  logic [2:0]  ld_addr,
    input  logic [7:0]  ld_data,
    input  logic [2:0]  dbg_addr,
    output logic [7:0]  dbg_data,
    output logic [3:0]  flags,
`ifdef ALU_SEQUENCER_RETIRE_CNT_EN
    output logic [15:0] retired,
`endif
    output logic        done
);

    localparam logic [2:0] c_ALU_OP_ADD = 3'd0;
    localparam logic [2:0] c_ALU_OP_SUB = 3'd1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t      r_state;
    logic [2:0]  r_rd;
    logic        r_setf;
    logic [7:0]  r_regs [NREGS];

    logic [8:0]  w_sum;
    logic        w_c;
    logic        w_v;
    logic [3:0]  w_flags;

    // alu_a/alu_b hold the captured operands through WB, so they double as
    // the internal operand latch for the carry/overflow computation.
    assign w_sum = {1'b0, alu_a} + {1'b0, alu_b};

    always_comb begin
        w_c = 1'b0;
        w_v = 1'b0;
        case (alu_op)
            c_ALU_OP_ADD: begin
                w_c = w_sum[8];
                w_v = (alu_a[7] == alu_b[7]) && (alu_out[7] != alu_a[7]);
            end
            c_ALU_OP_SUB: begin
                w_c = (alu_a >= alu_b);
                w_v = (alu_a[7] != alu_b[7]) && (alu_out[7] != alu_a[7]);
            end
            default: begin
                w_c = 1'b0;
                w_v = 1'b0;
            end
        endcase
    end

    assign w_flags  = {alu_out[7], (alu_out == 8'h00), w_c, w_v};
    assign dbg_data = r_regs[dbg_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rd      <= 3'd0;
            r_setf    <= 1'b0;
            in_ready  <= 1'b1;
            alu_a     <= 8'h00;
            alu_b     <= 8'h00;
            alu_op    <= 3'd0;
            alu_shamt <= 3'd0;
            flags     <= 4'h0;
            done      <= 1'b0;
`ifdef ALU_SEQUENCER_RETIRE_CNT_EN
            retired   <= 16'h0000;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Operands are read at the accept edge so they are stable
                    // on alu_* for the whole EXEC cycle.
                    if (in_valid) begin
                        r_rd      <= in_instr[12:10];
                        r_setf    <= in_instr[0];
                        alu_op    <= in_instr[15:13];
                        alu_a     <= r_regs[in_instr[9:7]];
                        alu_b     <= r_regs[in_instr[6:4]];
                        alu_shamt <= in_instr[3:1];
                        in_ready  <= 1'b0;
                        r_state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    done    <= 1'b1;
                    r_state <= S_WB;
                end
                S_WB: begin
                    if (r_setf) begin
                        flags <= w_flags;
                    end
`ifdef ALU_SEQUENCER_RETIRE_CNT_EN
                    retired <= retired + 16'd1;
`endif
                    in_ready <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: begin
                    in_ready <= 1'b1;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    // r0 is never written, so it reads zero from reset onward. The writeback
    // assignment comes last so it overrides a same-cycle load to rd.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else begin
            if (ld_en && (ld_addr != 3'd0)) begin
                r_regs[ld_addr] <= ld_data;
            end
            if ((r_state == S_WB) && (r_rd != 3'd0)) begin
                r_regs[r_rd] <= alu_out;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle issue/writeback controller that feeds the 8-bit ALU and consumes its registered result.
- Accepts 16-bit ALU instructions over a valid/ready handshake and holds the 8x8 register file.
- Drives the ALU operand, op and shamt inputs, writes the ALU result back to the register file, and maintains the NZCV flags register.
- Sits between fetch/decode (upstream) and the alu instance (instantiated externally, ports wired to alu_*).

Parameters:
- NREGS, 8, number of 8-bit registers; fixed at 8 because instruction fields are 3 bits.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  instruction present
- in_ready  output  1  sequencer can accept an instruction
- in_instr  input  16  [15:13] op, [12:10] rd, [9:7] ra, [6:4] rb, [3:1] shamt, [0] setf
- alu_a  output  8  ALU operand a
- alu_b  output  8  ALU operand b
- alu_op  output  3  ALU op; encodings per alu.vh
- alu_shamt  output  3  ALU shift amount
- alu_out  input  8  ALU registered result
- ld_en  input  1  external register load strobe
- ld_addr  input  3  load target
- ld_data  input  8  load value
- dbg_addr  input  3  debug read address
- dbg_data  output  8  combinational read of reg[dbg_addr]
- flags  output  4  {N,Z,C,V}, registered
- done  output  1  one-cycle pulse on writeback

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high (rst).
- Reset values: state=IDLE; all registers=0; flags=0; done=0; in_ready=1; alu_a/alu_b/alu_op/alu_shamt=0.
- Register r0 always reads 0. Writes to r0 (writeback or ld) are discarded.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture in_instr and go to EXEC.
  - in_valid without acceptance has no effect.
- EXEC (1 cycle):
  - in_ready=0.
  - alu_a=reg[ra], alu_b=reg[rb], alu_op=op, alu_shamt=shamt, all driven from the captured instruction.
  - Also latch the operand values internally for flag computation.
  - Next state is WB.
- WB (1 cycle):
  - in_ready=0.
  - alu_out is valid. Write reg[rd]<=alu_out at the end of the cycle.
  - done=1 during this cycle only. Next state is IDLE.
- Latency: 3 cycles from acceptance to the next in_ready. done asserts 2 cycles after the acceptance edge.
- Outside EXEC, alu_* outputs hold their last values.
- Flags (updated at the WB edge only if setf=1; otherwise held):
  - N=alu_out[7]; Z=(alu_out==0).
  - ALU_OP_ADD: C=carry out of the 9-bit a+b; V=(a[7]==b[7])&&(out[7]!=a[7]).
  - ALU_OP_SUB: C=(a>=b) unsigned, i.e. no borrow; V=(a[7]!=b[7])&&(out[7]!=a[7]).
  - All other ops: C=0, V=0.
- ld port:
  - Writes reg[ld_addr]<=ld_data on any clk edge with ld_en=1.
  - If ld and writeback target the same register in the same cycle, writeback wins.
  - A ld to ra/rb during EXEC affects the next instruction, not the current one.
- dbg_data reflects register contents after the write edge. There is no bypass within a cycle.
- Reset asserted mid-instruction aborts the instruction: no writeback, no done, flags=0.

Optional Feature:
- Macro: ALU_SEQUENCER_RETIRE_CNT_EN.
- Defined:
  - Adds output retired[15:0], reset to 0.
  - Increments at each WB edge (setf irrelevant) and wraps 0xFFFF->0x0000.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset: assert rst asynchronously mid-EXEC -> immediately flags=0, in_ready=1, dbg_data=0 for all addresses, no done pulse.
- ADD with carry: ld r1=0xFF, r2=0x01; issue ADD rd=3 ra=1 rb=2 setf=1 -> done 2 cycles after acceptance, r3=0x00, flags=0b0110 (Z,C).
- SUB overflow: r1=0x80, r2=0x01, SUB rd=4 setf=1 -> r4=0x7F, flags=0b0011 (C,V).
- r0 and setf=0: AND rd=0 ra=1 rb=2 with setf=0 -> r0 reads 0, flags unchanged.
- Handshake: hold in_valid=1 with back-to-back instructions -> acceptances exactly every 3 cycles; in_ready low in EXEC and WB.
- Load collision: ld_en to r3=0x55 in the same cycle as WB to r3=0xAA -> r3=0xAA. With the macro defined, preset the counter near 0xFFFF and retire instructions -> retired wraps to 0x0000.
